// File: rtl/led_status_arbiter.sv
// led_status_arbiter: shares the single status LED between REQ_NUM sources by
// strict priority (index 0 highest). A source shows solid-on or an N-flash code
// followed by a gap; with no request the LED runs an idle heartbeat.
// Optional feature macro: LED_ARB_PREEMPT_EN lets a higher-priority request
// abort a running flash sequence on the next tick.
module led_status_arbiter #(
  parameter int unsigned CLK_VALUE = 100000000,
  parameter int unsigned TICK_HZ   = 16,
  parameter int unsigned REQ_NUM   = 4,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned GAP_TICKS = 8,
  parameter int unsigned HB_TICKS  = 8
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [REQ_NUM-1:0]     req_i,
  input  logic [4*REQ_NUM-1:0]   code_i,
  output logic                   led_o,
  output logic [REQ_NUM-1:0]     gnt_o,
  output logic                   busy_o,
  output logic                   tick_o,
  output logic                   seq_done_o
);

  localparam int unsigned TICK_DIV = CLK_VALUE / TICK_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_A    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MAX_B    = (GAP_TICKS > HB_TICKS) ? GAP_TICKS : HB_TICKS;
  localparam int unsigned MAX_T    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned PH_W     = $clog2(MAX_T) + 1;
  localparam int unsigned IDX_W    = $clog2(REQ_NUM);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(GAP_TICKS - 1);
  localparam logic [PH_W-1:0]  HB_LAST  = PH_W'(HB_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SOLID     = 3'd1,
    S_FLASH_ON  = 3'd2,
    S_FLASH_OFF = 3'd3,
    S_GAP       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [3:0]         rem_q, rem_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               led_q, led_d;
  logic [REQ_NUM-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               seq_done_q, seq_done_d;

  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;
  logic [3:0]         arb_code;
  logic               higher_req;
  logic               preempt;
  logic               launch;

  // State register and all registered outputs
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      phase_q    <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      led_q      <= 1'b0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      led_q      <= led_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
    end
  end

  // Free-running prescaler; tick_q is high while the count sits at its last value
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) cnt_d = '0;
    tick_d = (cnt_d == CNT_LAST);
  end

  // Priority pick (lowest index wins) and detection of a higher-priority request
  always_comb begin
    arb_valid  = 1'b0;
    arb_idx    = '0;
    arb_code   = '0;
    higher_req = 1'b0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        arb_valid = 1'b1;
        arb_idx   = IDX_W'(i);
        arb_code  = code_i[4*i +: 4];
      end
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      if (req_i[i] && (i < int'(idx_q))) higher_req = 1'b1;
    end
  end

`ifdef LED_ARB_PREEMPT_EN
  assign preempt = higher_req;
`else
  assign preempt = 1'b0;
`endif

  // Next-state, phase, remaining-flash and owner logic; evaluated on ticks only
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    launch  = 1'b0;
    if (tick_q) begin
      case (state_q)
        S_IDLE: begin
          if (arb_valid)                launch  = 1'b1;
          else if (phase_q == HB_LAST)  phase_d = '0;
          else                          phase_d = phase_q + PH_W'(1);
        end
        S_SOLID: begin
          if (!req_i[idx_q]) begin
            state_d = S_IDLE;
            phase_d = '0;
          end else if (higher_req) begin
            launch = 1'b1;
          end
        end
        S_FLASH_ON: begin
          if (preempt) launch = 1'b1;
          else if (phase_q == ON_LAST) begin
            state_d = S_FLASH_OFF;
            phase_d = '0;
            rem_d   = rem_q - 4'd1;
          end else phase_d = phase_q + PH_W'(1);
        end
        S_FLASH_OFF: begin
          if (preempt) launch = 1'b1;
          else if (phase_q == OFF_LAST) begin
            state_d = (rem_q != 4'd0) ? S_FLASH_ON : S_GAP;
            phase_d = '0;
          end else phase_d = phase_q + PH_W'(1);
        end
        S_GAP: begin
          if (preempt) launch = 1'b1;
          else if (phase_q == GAP_LAST) begin
            if (arb_valid) launch = 1'b1;
            else begin
              state_d = S_IDLE;
              phase_d = '0;
            end
          end else phase_d = phase_q + PH_W'(1);
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase
      if (launch) begin
        idx_d   = arb_idx;
        phase_d = '0;
        rem_d   = arb_code;
        state_d = (arb_code == 4'd0) ? S_SOLID : S_FLASH_ON;
      end
    end
  end

  // Output decode from the upcoming state
  always_comb begin
    led_d      = led_q;
    busy_d     = (state_d != S_IDLE);
    seq_done_d = tick_q && (state_q == S_GAP) && !preempt && (phase_q == GAP_LAST);
    for (int i = 0; i < REQ_NUM; i++) begin
      gnt_d[i] = (state_d != S_IDLE) && (idx_d == IDX_W'(i));
    end
    case (state_d)
      S_SOLID, S_FLASH_ON: led_d = 1'b1;
      S_FLASH_OFF, S_GAP:  led_d = 1'b0;
      default: begin
        if (state_q != S_IDLE)                    led_d = 1'b0;
        else if (tick_q && (phase_q == HB_LAST))  led_d = ~led_q;
      end
    endcase
  end

  assign led_o      = led_q;
  assign gnt_o      = gnt_q;
  assign busy_o     = busy_q;
  assign tick_o     = tick_q;
  assign seq_done_o = seq_done_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Self-checking bench for led_status_arbiter. A tick-level reference model
// expands each granted code into a queue of per-tick LED values and compares
// every output on every cycle. Build with LED_ARB_PREEMPT_EN to model preemption.
module tb_led_status_arbiter;

  localparam int TICK_DIV = 4;
  localparam int ON_T     = 2;
  localparam int OFF_T    = 2;
  localparam int GAP_T    = 8;
  localparam int HB_T     = 8;

  logic        clk = 1'b0;
  logic        srst_i = 1'b1;
  logic [3:0]  req_i = '0;
  logic [15:0] code_i = '0;
  logic        led_o, busy_o, tick_o, seq_done_o;
  logic [3:0]  gnt_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  int owner = -1;
  bit solid = 1'b0;
  bit plan[$];
  bit m_led = 1'b0;
  bit m_done = 1'b0;
  int hb = 0;
  int cyc = 0;

  led_status_arbiter #(
    .CLK_VALUE(16), .TICK_HZ(4), .REQ_NUM(4),
    .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .GAP_TICKS(GAP_T), .HB_TICKS(HB_T)
  ) dut (
    .clk_i(clk), .srst_i(srst_i), .req_i(req_i), .code_i(code_i),
    .led_o(led_o), .gnt_o(gnt_o), .busy_o(busy_o), .tick_o(tick_o),
    .seq_done_o(seq_done_o)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [3:0] r, input int below);
    for (int k = 0; k < below; k++) if (r[k]) return k;
    return -1;
  endfunction

  task automatic go_idle();
    owner = -1;
    solid = 1'b0;
    plan.delete();
    m_led = 1'b0;
    hb    = 0;
  endtask

  task automatic grant(input int k);
    logic [3:0] c;
    c = code_i[4*k +: 4];
    owner = k;
    hb    = 0;
    plan.delete();
    if (c == 4'd0) begin
      solid = 1'b1;
      m_led = 1'b1;
    end else begin
      solid = 1'b0;
      for (int f = 0; f < int'(c); f++) begin
        for (int t = 0; t < ON_T; t++)  plan.push_back(1'b1);
        for (int t = 0; t < OFF_T; t++) plan.push_back(1'b0);
      end
      for (int t = 0; t < GAP_T; t++) plan.push_back(1'b0);
      m_led = plan[0];
    end
  endtask

  task automatic fsm_tick();
    int  w;
    bit  pre;
    if (owner < 0) begin
      w = lowest(req_i, 4);
      if (w >= 0) grant(w);
      else begin
        hb++;
        if (hb == HB_T) begin
          m_led = ~m_led;
          hb    = 0;
        end
      end
    end else if (solid) begin
      if (!req_i[owner]) go_idle();
      else begin
        w = lowest(req_i, owner);
        if (w >= 0) grant(w);
      end
    end else begin
      pre = 1'b0;
`ifdef LED_ARB_PREEMPT_EN
      pre = (lowest(req_i, owner) >= 0);
`endif
      if (pre) grant(lowest(req_i, owner));
      else begin
        void'(plan.pop_front());
        if (plan.size() == 0) begin
          m_done = 1'b1;
          w = lowest(req_i, 4);
          if (w >= 0) grant(w);
          else go_idle();
        end else m_led = plan[0];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // advance one clock, update the model from the inputs seen at the edge, compare
  task automatic step();
    logic [3:0] e_gnt;
    @(posedge clk);
    m_done = 1'b0;
    if (srst_i) begin
      go_idle();
      cyc = 0;
    end else begin
      if (cyc % TICK_DIV == TICK_DIV - 1) fsm_tick();
      cyc++;
    end
    #1;
    e_gnt = (owner >= 0) ? 4'(1 << owner) : 4'd0;
    chk("tick",     4'(tick_o),     4'(cyc % TICK_DIV == TICK_DIV - 1));
    chk("led",      4'(led_o),      4'(m_led));
    chk("gnt",      gnt_o,          e_gnt);
    chk("busy",     4'(busy_o),     4'(owner >= 0));
    chk("seq_done", 4'(seq_done_o), 4'(m_done));
  endtask

  initial begin
    int n;
    // reset, then idle heartbeat
    srst_i = 1'b1;
    repeat (3) step();
    chk("rst_led", 4'(led_o), 4'd0);
    chk("rst_gnt", gnt_o, 4'd0);
    srst_i = 1'b0;
    repeat (80) step();

    // source 2, code 3, held for one tick window
    code_i = 16'h0300;
    req_i  = 4'b0100;
    repeat (4) step();
    req_i  = 4'b0000;
    repeat (100) step();

    // simultaneous sources 0 and 1; source 1 served once source 0 lets go
    code_i = 16'h0021;
    req_i  = 4'b0011;
    repeat (20) step();
    req_i  = 4'b0010;
    repeat (80) step();
    req_i  = 4'b0000;
    repeat (60) step();

    // solid request held, then dropped
    code_i = 16'h0000;
    req_i  = 4'b0010;
    repeat (40) step();
    req_i  = 4'b0000;
    repeat (20) step();

    // source 3 code 5, source 0 arrives during flash 2
    code_i = 16'h5002;
    req_i  = 4'b1000;
    repeat (24) step();
    req_i  = 4'b1001;
    repeat (12) step();
    req_i  = 4'b0001;
    repeat (40) step();
    req_i  = 4'b0000;
    repeat (100) step();

    // reset pulse while flashing
    code_i = 16'h0400;
    req_i  = 4'b0100;
    n = 0;
    while (!(led_o === 1'b1 && busy_o === 1'b1) && n < 40) begin
      step();
      n++;
    end
    chk("wait_flash_on", 4'(n < 40), 4'd1);
    srst_i = 1'b1;
    step();
    chk("midrst_led",  4'(led_o),  4'd0);
    chk("midrst_busy", 4'(busy_o), 4'd0);
    srst_i = 1'b0;
    req_i  = 4'b0000;
    repeat (40) step();

    // randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) begin
        req_i = 4'($urandom);
        for (int k = 0; k < 4; k++) code_i[4*k +: 4] = 4'($urandom_range(0, 4));
      end
      srst_i = ($urandom_range(0, 399) == 0);
      step();
    end
    srst_i = 1'b0;
    req_i  = 4'b0000;
    repeat (100) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
